// File: rtl/fwft_frame_reader_pkg.sv
// ============================================================================
// Module   : fwft_frame_reader_pkg
// Purpose  : Shared types and header field positions for the FWFT frame reader.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fwft_frame_reader_pkg;

    typedef enum logic [0:0] {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam int LEN_LSB  = 0;
    localparam int LEN_W    = 16;
    localparam int USER_LSB = 16;

    localparam int ENTRY_DATA_W = 64;
    localparam int ENTRY_USER_W = 48;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] data;
        logic [ENTRY_USER_W-1:0] user;
        logic                    last;
    } skid_entry_t;

endpackage

`default_nettype wire

// File: rtl/fwft_frame_reader_skid_buf2.sv
// ============================================================================
// Module   : skid_buf2
// Purpose  : Generic 2-entry valid/ready buffer with registered head and
//            exposed occupancy.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module skid_buf2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_occ;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_occ != 2'd2);
    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_head;
    assign o_occ   = r_occ;

    assign w_push = i_valid & o_ready;
    assign w_pop  = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind whatever remains.
                    if (r_occ == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwft_frame_reader.sv
// ============================================================================
// Module   : fwft_frame_reader
// Purpose  : Drains a FWFT FIFO of length-prefixed frames, strips the header
//            and streams payload with per-word sideband and last flag.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fwft_frame_reader #(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 16,
    parameter int USER_W = 48
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic [USER_W-1:0] m_user,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       frame_count,
    output logic [15:0]       zero_len_count,
    output logic              busy
);

    import fwft_frame_reader_pkg::state_t;
    import fwft_frame_reader_pkg::HDR;
    import fwft_frame_reader_pkg::PAYLOAD;
    import fwft_frame_reader_pkg::LEN_LSB;
    import fwft_frame_reader_pkg::USER_LSB;
    import fwft_frame_reader_pkg::skid_entry_t;

    localparam int c_entry_w = $bits(skid_entry_t);

    state_t            r_state;
    logic [LEN_W-1:0]  r_remain;
    logic [USER_W-1:0] r_user;
    logic [31:0]       r_frame_count;
    logic [15:0]       r_zero_len_count;

    logic [LEN_W-1:0]  w_hdr_len;
    logic [USER_W-1:0] w_hdr_user;
    logic              w_last_word;
    logic              w_push;
    logic              w_skid_ready;
    logic              w_out_fire;
    logic [1:0]        w_occ;
    skid_entry_t       w_push_entry;
    skid_entry_t       w_head_entry;

    assign w_hdr_len   = fifo_dout[LEN_LSB +: LEN_W];
    assign w_hdr_user  = fifo_dout[USER_LSB +: USER_W];
    assign w_last_word = (r_remain == LEN_W'(1));

    // Gated only by buffer room, so m_ready never reaches the FIFO pop.
    assign fifo_rd_en = ~fifo_empty & w_skid_ready & ~srst;
    assign w_push     = fifo_rd_en & (r_state == PAYLOAD);

    assign w_push_entry = '{data: fifo_dout, user: r_user, last: w_last_word};

    skid_buf2 #(
        .WIDTH (c_entry_w)
    ) u_skid (
        .clk     (clk),
        .srst    (srst),
        .i_data  (w_push_entry),
        .i_valid (w_push),
        .o_ready (w_skid_ready),
        .o_data  (w_head_entry),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_occ   (w_occ)
    );

    assign m_data     = w_head_entry.data;
    assign m_user     = w_head_entry.user;
    assign m_last     = w_head_entry.last;
    assign w_out_fire = m_valid & m_ready;

    assign frame_count    = r_frame_count;
    assign zero_len_count = r_zero_len_count;
    assign busy           = (r_state == PAYLOAD) || (w_occ != 2'd0);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state          <= HDR;
            r_remain         <= '0;
            r_user           <= '0;
            r_frame_count    <= '0;
            r_zero_len_count <= '0;
        end else begin
            if (w_out_fire && m_last) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
            if (fifo_rd_en) begin
                case (r_state)
                    HDR: begin
                        r_user <= w_hdr_user;
                        if (w_hdr_len == '0) begin
                            if (r_zero_len_count != 16'hFFFF) begin
                                r_zero_len_count <= r_zero_len_count + 16'd1;
                            end
                        end else begin
                            r_remain <= w_hdr_len;
                            r_state  <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        r_remain <= r_remain - LEN_W'(1);
                        if (w_last_word) begin
                            r_state <= HDR;
                        end
                    end
                    default: begin
                        r_state <= HDR;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fwft_frame_reader.sv
// ============================================================================
// Module   : tb_fwft_frame_reader
// Purpose  : Directed self-checking bench for fwft_frame_reader with a queue
//            model of the upstream FWFT FIFO and an output capture monitor.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fwft_frame_reader;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic [63:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [63:0] m_data;
    logic [47:0] m_user;
    logic        m_last;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] frame_count;
    logic [15:0] zero_len_count;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] fq[$];
    logic [63:0] cap_data[$];
    logic [47:0] cap_user[$];
    logic        cap_last[$];
    logic        pop_now;

    always #5 clk = ~clk;

    fwft_frame_reader dut (
        .clk            (clk),
        .srst           (srst),
        .fifo_dout      (fifo_dout),
        .fifo_empty     (fifo_empty),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_user         (m_user),
        .m_last         (m_last),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .frame_count    (frame_count),
        .zero_len_count (zero_len_count),
        .busy           (busy)
    );

    function automatic logic [63:0] hdr(input logic [47:0] u, input logic [15:0] l);
        return {u, l};
    endfunction

    task automatic refresh_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_dout  = (fq.size() != 0) ? fq[0] : 64'd0;
    endtask

    task automatic push_word(input logic [63:0] w);
        fq.push_back(w);
        refresh_fifo();
    endtask

    task automatic clear_caps();
        cap_data.delete();
        cap_user.delete();
        cap_last.delete();
    endtask

    // Inputs only change right at the falling edge, so handshakes seen here hold through the rising edge.
    always begin
        @(negedge clk);
        #2;
        pop_now = fifo_rd_en;
        if (m_valid && m_ready && !srst) begin
            cap_data.push_back(m_data);
            cap_user.push_back(m_user);
            cap_last.push_back(m_last);
        end
        @(posedge clk);
        #1;
        if (pop_now && fq.size() != 0) begin
            void'(fq.pop_front());
            refresh_fifo();
        end
    end

    task automatic test_reset();
        srst = 1'b1;
        m_ready = 1'b1;
        push_word(64'hDEAD_0000_0000_0005);
        repeat (3) @(negedge clk);
        #3;
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_last !== 1'b0) begin n_err++; $display("FAIL reset_m_last: got %b want 0", m_last); end
        n_cmp++; if (m_data !== 64'd0) begin n_err++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        n_cmp++; if (m_user !== 48'd0) begin n_err++; $display("FAIL reset_m_user: got %h want 0", m_user); end
        n_cmp++; if (frame_count !== 32'd0) begin n_err++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
        n_cmp++; if (zero_len_count !== 16'd0) begin n_err++; $display("FAIL reset_zero_len: got %0d want 0", zero_len_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        fq.delete();
        refresh_fifo();
        srst = 1'b0;
        clear_caps();
    endtask

    task automatic test_basic_frame();
        int cyc;
        logic [63:0] exp_d [3];
        exp_d[0] = 64'h11; exp_d[1] = 64'h22; exp_d[2] = 64'h33;
        @(negedge clk);
        clear_caps();
        m_ready = 1'b1;
        push_word(hdr(48'hABC, 16'd3));
        for (int i = 0; i < 3; i++) push_word(exp_d[i]);
        cyc = 0;
        while (cap_data.size() < 3 && cyc < 50) begin @(negedge clk); #3; cyc++; end
        n_cmp++; if (cap_data.size() != 3) begin n_err++; $display("FAIL basic_count: got %0d want 3", cap_data.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < cap_data.size()) begin
                n_cmp++; if (cap_data[i] !== exp_d[i]) begin n_err++; $display("FAIL basic_data[%0d]: got %h want %h", i, cap_data[i], exp_d[i]); end
                n_cmp++; if (cap_user[i] !== 48'hABC) begin n_err++; $display("FAIL basic_user[%0d]: got %h want abc", i, cap_user[i]); end
                n_cmp++; if (cap_last[i] !== (i == 2)) begin n_err++; $display("FAIL basic_last[%0d]: got %b want %b", i, cap_last[i], (i == 2)); end
            end
        end
        @(negedge clk); #3;
        n_cmp++; if (frame_count !== 32'd1) begin n_err++; $display("FAIL basic_frame_count: got %0d want 1", frame_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b want 0", busy); end
    endtask

    task automatic test_zero_len();
        int cyc;
        @(negedge clk);
        clear_caps();
        push_word(hdr(48'h1, 16'd0));
        push_word(hdr(48'h77, 16'd1));
        push_word(64'h55);
        cyc = 0;
        while (cap_data.size() < 1 && cyc < 50) begin @(negedge clk); #3; cyc++; end
        @(negedge clk); #3;
        n_cmp++; if (cap_data.size() != 1) begin n_err++; $display("FAIL zlen_count_out: got %0d want 1", cap_data.size()); end
        if (cap_data.size() >= 1) begin
            n_cmp++; if (cap_data[0] !== 64'h55) begin n_err++; $display("FAIL zlen_data: got %h want 55", cap_data[0]); end
            n_cmp++; if (cap_user[0] !== 48'h77) begin n_err++; $display("FAIL zlen_user: got %h want 77", cap_user[0]); end
            n_cmp++; if (cap_last[0] !== 1'b1) begin n_err++; $display("FAIL zlen_last: got %b want 1", cap_last[0]); end
        end
        n_cmp++; if (zero_len_count !== 16'd1) begin n_err++; $display("FAIL zlen_counter: got %0d want 1", zero_len_count); end
        n_cmp++; if (frame_count !== 32'd2) begin n_err++; $display("FAIL zlen_frame_count: got %0d want 2", frame_count); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [63:0] ed;
        @(negedge clk);
        clear_caps();
        m_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            push_word(hdr(48'h100 + 48'(f), 16'd2));
            push_word(64'h1000 + 64'(f * 16));
            push_word(64'h1001 + 64'(f * 16));
        end
        cyc = 0;
        while (cap_data.size() < 8 && cyc < 60) begin @(negedge clk); #3; cyc++; end
        n_cmp++; if (cap_data.size() != 8) begin n_err++; $display("FAIL b2b_count: got %0d want 8", cap_data.size()); end
        // 12 pops (4 headers + 8 words) with the first payload visible one cycle after its pop.
        n_cmp++; if (cyc != 12) begin n_err++; $display("FAIL b2b_cycles: got %0d want 12", cyc); end
        for (int k = 0; k < 8; k++) begin
            if (k < cap_data.size()) begin
                ed = 64'h1000 + 64'((k / 2) * 16) + 64'(k % 2);
                n_cmp++; if (cap_data[k] !== ed) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", k, cap_data[k], ed); end
                n_cmp++; if (cap_user[k] !== 48'h100 + 48'(k / 2)) begin n_err++; $display("FAIL b2b_user[%0d]: got %h want %h", k, cap_user[k], 48'h100 + 48'(k / 2)); end
                n_cmp++; if (cap_last[k] !== (k % 2 == 1)) begin n_err++; $display("FAIL b2b_last[%0d]: got %b want %b", k, cap_last[k], (k % 2 == 1)); end
            end
        end
        @(negedge clk); #3;
        n_cmp++; if (frame_count !== 32'd6) begin n_err++; $display("FAIL b2b_frame_count: got %0d want 6", frame_count); end
    endtask

    task automatic test_backpressure();
        int cyc;
        @(negedge clk);
        clear_caps();
        m_ready = 1'b1;
        push_word(hdr(48'h5A5, 16'd6));
        for (int i = 0; i < 6; i++) push_word(64'h200 + 64'(i));
        cyc = 0;
        while (cap_data.size() < 2 && cyc < 50) begin @(negedge clk); #3; cyc++; end
        n_cmp++; if (cap_data.size() != 2) begin n_err++; $display("FAIL bp_pre_count: got %0d want 2", cap_data.size()); end
        // Word 0x202 is at the head when the sink stalls; 0x203 fills the second slot.
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk);
            m_ready = 1'b0;
            #3;
            n_cmp++; if (m_valid !== 1'b1 || m_data !== 64'h202 || m_user !== 48'h5A5 || m_last !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h u=%h l=%b want v=1 d=202 u=5a5 l=0", s, m_valid, m_data, m_user, m_last);
            end
            if (s >= 2) begin
                n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en[%0d]: got %b want 0", s, fifo_rd_en); end
            end
        end
        @(negedge clk);
        m_ready = 1'b1;
        cyc = 0;
        while (cap_data.size() < 6 && cyc < 50) begin @(negedge clk); #3; cyc++; end
        repeat (3) @(negedge clk);
        #3;
        n_cmp++; if (cap_data.size() != 6) begin n_err++; $display("FAIL bp_total: got %0d want 6", cap_data.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < cap_data.size()) begin
                n_cmp++; if (cap_data[i] !== 64'h200 + 64'(i) || cap_last[i] !== (i == 5)) begin
                    n_err++; $display("FAIL bp_seq[%0d]: got d=%h l=%b want d=%h l=%b", i, cap_data[i], cap_last[i], 64'h200 + 64'(i), (i == 5));
                end
            end
        end
        n_cmp++; if (frame_count !== 32'd7) begin n_err++; $display("FAIL bp_frame_count: got %0d want 7", frame_count); end
    endtask

    task automatic test_srst_mid_frame();
        int cyc;
        @(negedge clk);
        clear_caps();
        m_ready = 1'b1;
        push_word(hdr(48'h321, 16'd5));
        push_word(64'h301);
        push_word(64'h302);
        cyc = 0;
        while (cap_data.size() < 2 && cyc < 50) begin @(negedge clk); #3; cyc++; end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL srst_busy_before: got %b want 1", busy); end
        srst = 1'b1;
        fq.delete();
        refresh_fifo();
        @(negedge clk);
        srst = 1'b0;
        clear_caps();
        push_word(hdr(48'h9, 16'd1));
        push_word(64'h777);
        #3;
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL srst_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (frame_count !== 32'd0) begin n_err++; $display("FAIL srst_frame_count: got %0d want 0", frame_count); end
        n_cmp++; if (zero_len_count !== 16'd0) begin n_err++; $display("FAIL srst_zero_len: got %0d want 0", zero_len_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL srst_busy: got %b want 0", busy); end
        cyc = 0;
        while (cap_data.size() < 1 && cyc < 50) begin @(negedge clk); #3; cyc++; end
        @(negedge clk); #3;
        n_cmp++; if (cap_data.size() != 1) begin n_err++; $display("FAIL srst_post_count: got %0d want 1", cap_data.size()); end
        if (cap_data.size() >= 1) begin
            n_cmp++; if (cap_data[0] !== 64'h777 || cap_user[0] !== 48'h9 || cap_last[0] !== 1'b1) begin
                n_err++; $display("FAIL srst_post_word: got d=%h u=%h l=%b want d=777 u=9 l=1", cap_data[0], cap_user[0], cap_last[0]);
            end
        end
        n_cmp++; if (frame_count !== 32'd1) begin n_err++; $display("FAIL srst_post_frames: got %0d want 1", frame_count); end
    endtask

    task automatic test_zero_len_saturation();
        int cyc;
        @(negedge clk);
        clear_caps();
        for (int i = 0; i < 300; i++) push_word(hdr(48'(i), 16'd0));
        cyc = 0;
        while (fq.size() != 0 && cyc < 400) begin @(negedge clk); #3; cyc++; end
        repeat (2) @(negedge clk);
        #3;
        n_cmp++; if (zero_len_count !== 16'd300) begin n_err++; $display("FAIL zsat_300: got %0d want 300", zero_len_count); end
        n_cmp++; if (cap_data.size() != 0) begin n_err++; $display("FAIL zsat_no_output: got %0d want 0", cap_data.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zsat_busy: got %b want 0", busy); end
        @(negedge clk);
        force dut.r_zero_len_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_zero_len_count;
        @(negedge clk);
        push_word(hdr(48'hBEEF, 16'd0));
        repeat (3) @(negedge clk);
        #3;
        n_cmp++; if (fq.size() != 0) begin n_err++; $display("FAIL zsat_hdr_popped: got %0d left want 0", fq.size()); end
        n_cmp++; if (zero_len_count !== 16'hFFFF) begin n_err++; $display("FAIL zsat_saturate: got %h want ffff", zero_len_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_zero_len();
        test_back_to_back();
        test_backpressure();
        test_srst_mid_frame();
        test_zero_len_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
